cache_mem_adapter: RTL
======================

# cache_mem_adapter

Memory-side stage directly downstream of the cache controller FSM. It turns the controller's single-cycle `mem_read` / `mem_write` requests into a burst of `LINE_WORDS` word transfers on the main-memory req/ack bus. It assembles read data into a full line and returns a one-cycle `ca_resp` when the whole line has been written back or fetched.

## Interface
- `ADDR_W`, 32, byte-address width
- `WORD_W`, 32, memory word width in bits
- `LINE_WORDS`, 4, words per cache line; power of two, ≥ 2
- Derived, not overridable: `OFF_W = $clog2(LINE_WORDS) + $clog2(WORD_W/8)`

Ports:
- `clk`  in  1  clock; all logic is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_read`  in  1  fetch-line request pulse from the cache FSM
- `mem_write`  in  1  write-back-line request pulse from the cache FSM
- `mem_addr`  in  ADDR_W  line byte address; low OFF_W bits ignored
- `mem_wline`  in  LINE_WORDS*WORD_W  line to write back; word i at `[i*WORD_W +: WORD_W]`
- `mem_rline`  out  LINE_WORDS*WORD_W  fetched line, same packing
- `ca_resp`  out  1  one-cycle pulse: transfer complete
- `busy`  out  1  transfer in progress; requests are ignored while high
- `error`  out  1  one-cycle pulse on an illegal request
- `mm_req`  out  1  memory beat request
- `mm_we`  out  1  beat is a write
- `mm_addr`  out  ADDR_W  beat byte address
- `mm_wdata`  out  WORD_W  beat write data
- `mm_ack`  in  1  beat accepted; read data valid on `mm_rdata` in the same cycle
- `mm_rdata`  in  WORD_W  beat read data

## Operation
- States: IDLE, XFER, RESP.
- **IDLE**
  - On `mem_write`: capture the line base `{mem_addr[ADDR_W-1:OFF_W], 0}`, capture `mem_wline`, set op = write, clear `beat`, go to XFER.
  - Else on `mem_read`: same capture with op = read, go to XFER.
  - On `mem_read && mem_write` together: write wins, the read is dropped, and `error` pulses.
- **XFER**
  - Drive `mm_req=1`.
  - `mm_we` = op.
  - `mm_addr` = base + `beat*(WORD_W/8)`.
  - `mm_wdata` = captured word[`beat`].
  - On `mm_ack`:
    - Read op: store `mm_rdata` into `mem_rline` word[`beat`].
    - If `beat == LINE_WORDS-1`, go to RESP; otherwise increment `beat`.
  - Without `mm_ack`: hold all `mm_*` outputs stable.
- **RESP**: `ca_resp=1` for exactly one cycle, then go to IDLE.
- `busy` is high in XFER and RESP.
- Requests arriving while busy are ignored and `error` pulses.
- `mm_ack` while `mm_req` is low is ignored.
- `mem_rline` holds its value until the next read beat overwrites it. Write ops never modify it.
- `beat` is `$clog2(LINE_WORDS)` bits wide. Address arithmetic is modulo 2^ADDR_W; wrap above the top line is not special-cased.

## Timing
- Reset values: state IDLE; `mm_req`, `mm_we`, `ca_resp`, `busy`, `error` = 0; `mm_addr`, `mm_wdata`, `beat` = 0; `mem_rline` = 0.
- All outputs are registered.
- Request sampled at edge N:
  - `mm_req` is high from cycle N+1.
  - With `mm_ack` tied high, beats complete at N+1 … N+LINE_WORDS.
  - `ca_resp` is high in cycle N+LINE_WORDS+1.
  - The next request is accepted from cycle N+LINE_WORDS+2.
- Each wait cycle without `mm_ack` adds one cycle of latency.
- Consecutive beats run back-to-back: `mm_req` stays high across beats with no bubble.
- `mem_rline` is fully valid in the cycle `ca_resp` is high.
- `rst` mid-transfer: the transfer is aborted at that edge and all outputs take their reset values in the next cycle. No `ca_resp` is issued. Memory must tolerate an abandoned beat.

## Structure
- Shared package `cache_pkg` holds:
  - the adapter state enum `ca_state_t` (IDLE/XFER/RESP);
  - constants `WORD_W` and `LINE_WORDS`;
  - the memory-op typedef (read/write), also used by the cache FSM.
- One sub-module is natural: `cache_line_buf`, a LINE_WORDS×WORD_W register with per-word write-enable and an indexed read. It is instantiated twice: write-back capture and `mem_rline` assembly.

## Test plan
- Write-back, `mm_ack` tied high, `mem_addr=0x0000_1234`, line words `0xA0..0xA3`:
  - `mm_addr` takes 0x1230, 0x1234, 0x1238, 0x123C on cycles 1–4 with `mm_we=1` and data A0..A3.
  - `ca_resp` is high on cycle 5 only.
- Read with ack every 3rd cycle, `mm_rdata = 0xB0 + beat`:
  - `mm_addr` and `mm_we` are held stable during waits.
  - `mem_rline = {B3,B2,B1,B0}` when `ca_resp` pulses.
- `mem_read` and `mem_write` in the same cycle:
  - `error` pulses once.
  - Only write beats are issued.
- `mem_read` pulse while busy: ignored, `error` pulses, and the current transfer completes unchanged.
- `rst` asserted after beat 1 of a read: next cycle `mm_req=0`, `busy=0`, `mem_rline=0`, and no `ca_resp` follows.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache types: adapter state, memory-op kind and line geometry.
// Imported by the cache controller FSM and the memory adapter.
package cache_pkg;

   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 4;

   typedef enum logic [1:0] {
      CA_IDLE = 2'd0,
      CA_XFER = 2'd1,
      CA_RESP = 2'd2
   } ca_state_t;

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } mem_op_t;

endpackage

// File: rtl/cache_line_buf.sv
// One cache line of registers with per-word write enables
// and an indexed single-word read port.
module cache_line_buf #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [LINE_WORDS-1:0]        we_i,
   input  logic [LINE_WORDS*WORD_W-1:0] wline_i,
   input  logic [IDX_W-1:0]             idx_i,
   output logic [LINE_WORDS*WORD_W-1:0] line_o,
   output logic [WORD_W-1:0]            word_o
);

   logic [LINE_WORDS-1:0][WORD_W-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            if (we_i[i]) begin
               mem_q[i] <= wline_i[i*WORD_W +: WORD_W];
            end
         end
      end
   end

   assign line_o = mem_q;
   assign word_o = mem_q[idx_i];

endmodule

// File: rtl/cache_mem_adapter.sv
// Turns single-cycle line fetch/write-back requests into a burst
// of word beats on the main-memory req/ack bus.
module cache_mem_adapter #(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = cache_pkg::WORD_W,
   parameter int LINE_WORDS = cache_pkg::LINE_WORDS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [ADDR_W-1:0]            mem_addr,
   input  logic [LINE_WORDS*WORD_W-1:0] mem_wline,
   output logic [LINE_WORDS*WORD_W-1:0] mem_rline,
   output logic                         ca_resp,
   output logic                         busy,
   output logic                         error,
   output logic                         mm_req,
   output logic                         mm_we,
   output logic [ADDR_W-1:0]            mm_addr,
   output logic [WORD_W-1:0]            mm_wdata,
   input  logic                         mm_ack,
   input  logic [WORD_W-1:0]            mm_rdata
);
   import cache_pkg::*;

   localparam int BYTES  = WORD_W / 8;
   localparam int IDX_W  = $clog2(LINE_WORDS);
   localparam int OFF_W  = IDX_W + $clog2(BYTES);
   localparam int LINE_W = LINE_WORDS * WORD_W;

   ca_state_t            state_q, state_d;
   mem_op_t              op_q, op_d;
   logic [IDX_W-1:0]     beat_q, beat_d;
   logic                 mm_req_q, mm_req_d;
   logic                 mm_we_q, mm_we_d;
   logic [ADDR_W-1:0]    mm_addr_q, mm_addr_d;
   logic [WORD_W-1:0]    mm_wdata_q, mm_wdata_d;
   logic                 ca_resp_q, ca_resp_d;
   logic                 busy_q, busy_d;
   logic                 error_q, error_d;

   logic [LINE_WORDS-1:0] wb_we, rb_we;
   logic [IDX_W-1:0]      wb_idx;
   logic [WORD_W-1:0]     wb_word;
   logic [LINE_W-1:0]     wb_line_unused;
   logic [WORD_W-1:0]     rb_word_unused;
   logic [ADDR_W-1:0]     base;

   assign base   = {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign wb_idx = beat_q + IDX_W'(1);

   cache_line_buf #(
      .WORD_W    (WORD_W),
      .LINE_WORDS(LINE_WORDS)
   ) u_wbuf (
      .clk    (clk),
      .rst    (rst),
      .we_i   (wb_we),
      .wline_i(mem_wline),
      .idx_i  (wb_idx),
      .line_o (wb_line_unused),
      .word_o (wb_word)
   );

   cache_line_buf #(
      .WORD_W    (WORD_W),
      .LINE_WORDS(LINE_WORDS)
   ) u_rbuf (
      .clk    (clk),
      .rst    (rst),
      .we_i   (rb_we),
      .wline_i({LINE_WORDS{mm_rdata}}),
      .idx_i  (beat_q),
      .line_o (mem_rline),
      .word_o (rb_word_unused)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      beat_d     = beat_q;
      mm_req_d   = mm_req_q;
      mm_we_d    = mm_we_q;
      mm_addr_d  = mm_addr_q;
      mm_wdata_d = mm_wdata_q;
      error_d    = 1'b0;
      wb_we      = '0;
      rb_we      = '0;
      unique case (state_q)
         CA_IDLE: begin
            if (mem_write || mem_read) begin
               op_d       = mem_write ? MEM_WRITE : MEM_READ;
               beat_d     = '0;
               mm_req_d   = 1'b1;
               mm_we_d    = mem_write;
               mm_addr_d  = base;
               mm_wdata_d = mem_wline[WORD_W-1:0];
               wb_we      = '1;
               error_d    = mem_read && mem_write;
               state_d    = CA_XFER;
            end
         end
         CA_XFER: begin
            error_d = mem_read || mem_write;
            if (mm_ack) begin
               if (op_q == MEM_READ) begin
                  rb_we = LINE_WORDS'(1) << beat_q;
               end
               if (beat_q == IDX_W'(LINE_WORDS - 1)) begin
                  mm_req_d = 1'b0;
                  mm_we_d  = 1'b0;
                  state_d  = CA_RESP;
               end else begin
                  // next beat's word is prefetched from the capture buffer
                  beat_d     = wb_idx;
                  mm_addr_d  = mm_addr_q + ADDR_W'(BYTES);
                  mm_wdata_d = wb_word;
               end
            end
         end
         CA_RESP: begin
            error_d = mem_read || mem_write;
            state_d = CA_IDLE;
         end
         default: state_d = CA_IDLE;
      endcase
      ca_resp_d = (state_d == CA_RESP);
      busy_d    = (state_d != CA_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CA_IDLE;
         op_q       <= MEM_READ;
         beat_q     <= '0;
         mm_req_q   <= 1'b0;
         mm_we_q    <= 1'b0;
         mm_addr_q  <= '0;
         mm_wdata_q <= '0;
         ca_resp_q  <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         beat_q     <= beat_d;
         mm_req_q   <= mm_req_d;
         mm_we_q    <= mm_we_d;
         mm_addr_q  <= mm_addr_d;
         mm_wdata_q <= mm_wdata_d;
         ca_resp_q  <= ca_resp_d;
         busy_q     <= busy_d;
         error_q    <= error_d;
      end
   end

   assign ca_resp  = ca_resp_q;
   assign busy     = busy_q;
   assign error    = error_q;
   assign mm_req   = mm_req_q;
   assign mm_we    = mm_we_q;
   assign mm_addr  = mm_addr_q;
   assign mm_wdata = mm_wdata_q;

endmodule
